// File: rtl/key_provision_loader.sv
// Serial key loader: assembles the logic-locking key and releases the locked core.
// Optional parity check on the serial stream: define KEYLOAD_PARITY_CHECK_EN.
module key_provision_loader #(
    parameter int NKEYS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_start,
    input  logic             ser_valid,
    input  logic             ser_data,
    output logic             ser_ready,
    output logic [NKEYS-1:0] keyinput,
    output logic             key_valid,
    output logic             core_hold,
    output logic             load_err
);

    localparam int CW = $clog2(NKEYS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        COMMIT,
        LOCKED,
        ERROR
`ifdef KEYLOAD_PARITY_CHECK_EN
        ,
        PARITY
`endif
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [NKEYS-1:0] shreg;
    logic             xfer;
    logic             last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    if (xfer && last) begin
`ifdef KEYLOAD_PARITY_CHECK_EN
                        state_next = PARITY;
`else
                        state_next = COMMIT;
`endif
                    end
                end
`ifdef KEYLOAD_PARITY_CHECK_EN
                PARITY: begin
                    // Even parity over data plus parity bit.
                    if (xfer) begin
                        state_next = (^shreg ^ ser_data) ? ERROR : COMMIT;
                    end
                end
`endif
                COMMIT:  state_next = LOCKED;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        ser_ready = (state == SHIFT);
`ifdef KEYLOAD_PARITY_CHECK_EN
        ser_ready = ser_ready || (state == PARITY);
        load_err  = (state == ERROR);
`else
        load_err  = 1'b0;
`endif
        xfer = ser_valid & ser_ready;
        last = (cnt == CW'(NKEYS - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            shreg     <= '0;
            keyinput  <= '0;
            key_valid <= 1'b0;
            core_hold <= 1'b1;
        end else if (load_start) begin
            cnt       <= '0;
            shreg     <= '0;
            key_valid <= 1'b0;
            core_hold <= 1'b1;
        end else begin
            if (state == SHIFT && xfer) begin
                shreg <= (shreg << 1) | NKEYS'(ser_data);
                cnt   <= cnt + CW'(1);
            end
            if (state == COMMIT) begin
                keyinput <= shreg;
            end
            if (state == ERROR || state_next == ERROR) begin
                keyinput <= '0;
            end
            key_valid <= (state == LOCKED);
            core_hold <= (state != LOCKED);
        end
    end

endmodule

// File: tb/tb_key_provision_loader.sv
// Scoreboard bench for key_provision_loader with NKEYS=4.
// Parity scenarios build when KEYLOAD_PARITY_CHECK_EN is defined.
module tb_key_provision_loader;

    localparam int NK = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_start;
    logic          ser_valid;
    logic          ser_data;
    logic          ser_ready;
    logic [NK-1:0] keyinput;
    logic          key_valid;
    logic          core_hold;
    logic          load_err;

    int n_run  = 0;
    int n_fail = 0;
    logic [NK-1:0] exp_q[$];

    key_provision_loader #(.NKEYS(NK)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_ready  (ser_ready),
        .keyinput   (keyinput),
        .key_valid  (key_valid),
        .core_hold  (core_hold),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        int n;
        ser_valid = 1'b1;
        ser_data  = b;
        n = 0;
        while (!ser_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(n < 20), 32'd1);
        tick();
        ser_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Waits for key_valid after the last transfer and checks the popped key.
    task automatic wait_commit();
        int n;
        logic [NK-1:0] exp;
        n = 0;
        while (!key_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd2);
        check("hold_rel", 32'(core_hold), 32'd0);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check("key", 32'(keyinput), 32'(exp));
        end
    endtask

    task automatic load(input logic [NK-1:0] k, input int gap);
        start();
        check("ready_first", 32'(ser_ready), 32'd1);
        for (int i = NK - 1; i >= 0; i--) begin
            send_bit(k[i], (i == 0) ? 0 : gap);
        end
`ifdef KEYLOAD_PARITY_CHECK_EN
        send_bit(^k, 0);
`endif
        exp_q.push_back(k);
        wait_commit();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_key"}, 32'(keyinput), 32'd0);
        check({tag, "_kv"}, 32'(key_valid), 32'd0);
        check({tag, "_hold"}, 32'(core_hold), 32'd1);
        check({tag, "_rdy"}, 32'(ser_ready), 32'd0);
        check({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        ser_valid  = 1'b0;
        ser_data   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_vals("rst");

        load(4'hB, 0);
        load(4'hB, 3);

        // Abort after two bits, reload a different key.
        start();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        start();
        check("abort_kv", 32'(key_valid), 32'd0);
        check("abort_old", 32'(keyinput), 32'hB);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("mid_kv", 32'(key_valid), 32'd0);
        send_bit(1'b0, 0);
`ifdef KEYLOAD_PARITY_CHECK_EN
        send_bit(1'b0, 0);
`endif
        exp_q.push_back(4'h6);
        wait_commit();

        // load_start coincident with a transfer discards that bit.
        start();
        ser_valid  = 1'b1;
        ser_data   = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ser_valid  = 1'b0;
        send_bit(1'b0, 0);
        send_bit(1'b1, 1);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
`ifdef KEYLOAD_PARITY_CHECK_EN
        send_bit(1'b0, 0);
`endif
        exp_q.push_back(4'h5);
        wait_commit();

        // Reset mid-reload from a locked key.
        load(4'hB, 0);
        start();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("midrst");

`ifdef KEYLOAD_PARITY_CHECK_EN
        load(4'hB, 1);
        start();
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        repeat (3) tick();
        check("perr_err", 32'(load_err), 32'd1);
        check("perr_key", 32'(keyinput), 32'd0);
        check("perr_kv", 32'(key_valid), 32'd0);
        check("perr_hold", 32'(core_hold), 32'd1);
        load(4'h6, 0);
        check("perr_clr", 32'(load_err), 32'd0);
`else
        load(4'hB, 0);
        ser_valid = 1'b1;
        ser_data  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("extra_rdy", 32'(ser_ready), 32'd0);
            tick();
        end
        ser_valid = 1'b0;
        check("extra_key", 32'(keyinput), 32'hB);
        check("extra_kv", 32'(key_valid), 32'd1);
        check("extra_err", 32'(load_err), 32'd0);
`endif
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
